// File: rtl/scope_sample_fifo.sv
// Sample capture buffer: decimates ADC samples into a single-clock FIFO
// drained by the CPU over an Avalon-MM slave. fifo_full feeds the
// end-of-capture PIO; the IDLE/CAPTURE/DONE machine frames each acquisition.
module scope_sample_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              fifo_full,
  output logic              fifo_empty
);

  localparam int unsigned            DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]    FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count, count_d;
  logic                    overflow, cont;
  logic [15:0]             div, dcnt;
  logic                    bus_rd, bus_wr, ctrl_wr, arm, flush;
  logic                    is_full, pop, accept, push, dropped;
  logic [31:0]             status;
  logic                    unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  assign bus_rd  = chipselect & ~read_n;
  assign bus_wr  = chipselect & ~write_n;
  assign ctrl_wr = bus_wr && (address == 2'd1);
  assign arm     = ctrl_wr & writedata[0];
  assign flush   = ctrl_wr & (writedata[0] | writedata[1]);

  // Push eligibility uses count at the start of the cycle, so a
  // simultaneous pop never makes room for the incoming sample.
  assign is_full = (count == FULL_CNT);
  assign pop     = bus_rd && (address == 2'd0) && (count != '0);
  assign accept  = (state_q == CAPTURE) && sample_valid && (dcnt == '0) && !flush;
  assign push    = accept && !is_full;
  assign dropped = accept && is_full;

  // Next-state logic: ARM dominates CLEAR; a non-continuous capture ends on the filling push
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = CAPTURE;
    end else if (flush) begin
      state_d = IDLE;
    end else if ((state_q == CAPTURE) && push && (count == FULL_CNT - 1'b1) && !cont) begin
      state_d = DONE;
    end
  end

  // Next occupancy: flush wins over any concurrent push or pop
  always_comb begin
    count_d = count;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count + 1'b1;
        2'b01:   count_d = count - 1'b1;
        default: count_d = count;
      endcase
    end
  end

  // Status word as seen at the strobe cycle
  always_comb begin
    status                       = '0;
    status[0]                    = fifo_full;
    status[1]                    = fifo_empty;
    status[2]                    = overflow;
    status[4:3]                  = state_q;
    status[5]                    = cont;
    status[16 +: DEPTH_LOG2 + 1] = count;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Sample storage; contents are not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  // Pointers, flags, decimator, control registers and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
      dcnt       <= '0;
      div        <= '0;
      cont       <= 1'b0;
      readdata   <= '0;
    end else begin
      count      <= count_d;
      fifo_full  <= (count_d == FULL_CNT);
      fifo_empty <= (count_d == '0);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (flush)        overflow <= 1'b0;
      else if (dropped) overflow <= 1'b1;

      if (arm) begin
        dcnt <= '0;
      end else if ((state_q == CAPTURE) && sample_valid) begin
        dcnt <= (dcnt == '0) ? div : dcnt - 1'b1;
      end

      if (arm) cont <= writedata[2];
      if (bus_wr && (address == 2'd2)) div <= writedata[15:0];

      // readdata holds its last value between read strobes
      if (bus_rd) begin
        case (address)
          2'd0:    readdata <= pop ? 32'(mem[rd_ptr]) : '0;
          2'd1:    readdata <= status;
          2'd2:    readdata <= {16'h0000, div};
          default: readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_sample_fifo.sv
// Directed bench for scope_sample_fifo: a vector table for basic register and
// FIFO behaviour, followed by hand sequences for fill, decimation, overflow,
// flush priority and asynchronous reset.
module tb_scope_sample_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [7:0]  sample_data;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        fifo_full;
  logic        fifo_empty;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        full_watch = 1'b0;
  int unsigned full_rises = 0;

  scope_sample_fifo #(.DATA_W(8), .DEPTH_LOG2(9)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .address      (address),
    .chipselect   (chipselect),
    .read_n       (read_n),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
  );

  always #5 clk = ~clk;

  always @(posedge fifo_full) if (full_watch) full_rises++;

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        cs;
    logic        rn;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_empty;
    logic        exp_full;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    tick();
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic send(input logic [7:0] v);
    sample_valid = 1'b1; sample_data = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic status_is(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(2'd1, d);
    check(name, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;

    // sv   sd     cs   rn   wn   addr  wdata         chk  exp_rd        emp  full
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0000, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_0001, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0002_0008, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_0011, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_0022, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_0033, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd2, 32'hABCD_1234, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'h0000_1234, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'h0000_1234, 1'b1, 1'b0};

    reset_n = 1'b0; sample_valid = 1'b0; sample_data = '0; address = '0;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = '0;
    #12;
    check("reset_readdata", readdata, 32'h0);
    check("reset_full", {31'b0, fifo_full}, 32'h0);
    check("reset_empty", {31'b0, fifo_empty}, 32'h1);
    reset_n = 1'b1;
    #2;
    tick();
    status_is("reset_status", 32'h0000_0002);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      sample_valid = vecs[i].sv; sample_data = vecs[i].sd;
      chipselect = vecs[i].cs; read_n = vecs[i].rn; write_n = vecs[i].wn;
      address = vecs[i].addr; writedata = vecs[i].wd;
      tick();
      if (vecs[i].chk_rd) check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_empty", i), {31'b0, fifo_empty}, {31'b0, vecs[i].exp_empty});
      check($sformatf("vec%0d_full", i), {31'b0, fifo_full}, {31'b0, vecs[i].exp_full});
    end
    sample_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;

    // Fill and stop
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'h1);
    for (int i = 0; i < 512; i++) begin
      send(i[7:0]);
      if (i == 510) check("fill_full_before_last", {31'b0, fifo_full}, 32'h0);
    end
    check("fill_full_after_last", {31'b0, fifo_full}, 32'h1);
    status_is("fill_status_done", 32'h0200_0011);
    send(8'h5A);
    status_is("fill_status_513th", 32'h0200_0011);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    for (int i = 0; i < 512; i++) begin
      tick();
      check($sformatf("drain%0d", i), readdata, 32'(i % 256));
      if (i == 0) check("fill_full_falls", {31'b0, fifo_full}, 32'h0);
    end
    chipselect = 1'b0; read_n = 1'b1;
    check("drain_empty", {31'b0, fifo_empty}, 32'h1);
    bus_read(2'd0, d);
    check("drain_513th", d, 32'h0);

    // Decimation by 4
    bus_write(2'd2, 32'd3);
    bus_write(2'd1, 32'h1);
    for (int i = 0; i < 40; i++) send(i[7:0]);
    status_is("decim_status", 32'h000A_0008);
    for (int i = 0; i < 10; i++) begin
      bus_read(2'd0, d);
      check($sformatf("decim_data%0d", i), d, 32'(4 * i));
    end

    // Continuous capture with overflow
    bus_write(2'd2, 32'd0);
    bus_write(2'd1, 32'h5);
    for (int i = 0; i < 515; i++) send(i[7:0]);
    status_is("cont_status_ovf", 32'h0200_002D);
    bus_read(2'd0, d);
    check("cont_pop_head", d, 32'h0);
    check("cont_full_after_pop", {31'b0, fifo_full}, 32'h0);
    send(8'hAA);
    check("cont_full_refill", {31'b0, fifo_full}, 32'h1);
    status_is("cont_status_refill", 32'h0200_002D);

    // Simultaneous push and pop at count 5
    bus_write(2'd1, 32'h1);
    for (int i = 10; i < 15; i++) send(i[7:0]);
    sample_valid = 1'b1; sample_data = 8'd99;
    bus_read(2'd0, d);
    sample_valid = 1'b0;
    check("pushpop_head", d, 32'd10);
    status_is("pushpop_status", 32'h0005_0008);
    for (int i = 0; i < 5; i++) begin
      bus_read(2'd0, d);
      check($sformatf("pushpop_drain%0d", i), d, (i == 4) ? 32'd99 : 32'(11 + i));
    end

    // Flush and priority
    bus_write(2'd1, 32'h1);
    for (int i = 0; i < 100; i++) send(i[7:0]);
    status_is("flush_pre", 32'h0064_0008);
    bus_write(2'd1, 32'h2);
    status_is("flush_clear", 32'h0000_0002);
    send(8'h77);
    status_is("flush_idle_ignores", 32'h0000_0002);
    bus_write(2'd1, 32'h3);
    status_is("flush_arm_clear", 32'h0000_000A);
    for (int i = 0; i < 3; i++) send(i[7:0]);
    sample_valid = 1'b1; sample_data = 8'h44;
    bus_write(2'd1, 32'h1);
    sample_valid = 1'b0;
    status_is("flush_arm_with_sample", 32'h0000_000A);

    // Asynchronous reset mid-capture at count 300
    bus_write(2'd2, 32'd2);
    bus_write(2'd1, 32'h1);
    for (int i = 0; i < 900; i++) send(i[7:0]);
    status_is("areset_pre", 32'h012C_0008);
    full_watch = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_readdata", readdata, 32'h0);
    check("areset_full", {31'b0, fifo_full}, 32'h0);
    check("areset_empty", {31'b0, fifo_empty}, 32'h1);
    #3;
    reset_n = 1'b1;
    tick();
    status_is("areset_status", 32'h0000_0002);
    bus_read(2'd2, d);
    check("areset_div", d, 32'h0);
    full_watch = 1'b0;
    check("areset_no_full_pulse", 32'(full_rises), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
